// File: rtl/rv_div_ctrl.sv
// Divide sequencer for RV64M: resolves special cases locally, conditions operands
// for the signed SRT divider, and corrects/selects/sign-extends the returned result.
module rv_div_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic        word_i,
    input  logic [63:0] rs1_i,
    input  logic [63:0] rs2_i,
    input  logic        kill_i,
    output logic        res_vld_o,
    output logic [63:0] res_o,
    output logic        busy_o,
    output logic        div_vld_o,
    output logic [63:0] div_op1_o,
    output logic [63:0] div_op2_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_quo_i,
    input  logic [63:0] div_rem_i
);

    typedef enum logic [2:0] {IDLE, ISSUE, RUN, FIX, OUT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        word_q, word_d;
    logic        fix_q, fix_d;
    logic        a0_q, a0_d;
    logic        kill_q, kill_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] res_q, res_d;
    logic [63:0] op1_q, op1_d;
    logic [63:0] op2_q, op2_d;

    logic        uns, special, fix_c, accept, r2_ge;
    logic [63:0] a_c, b_c, spec_q, spec_r, r2, sel, res_sel;

    always_comb begin
        uns = op_i[0];
        if (word_i) begin
            a_c = uns ? {32'h0, rs1_i[31:0]} : {{32{rs1_i[31]}}, rs1_i[31:0]};
            b_c = uns ? {32'h0, rs2_i[31:0]} : {{32{rs2_i[31]}}, rs2_i[31:0]};
        end else begin
            a_c = rs1_i;
            b_c = rs2_i;
        end
        special = 1'b0;
        fix_c   = 1'b0;
        spec_q  = '0;
        spec_r  = a_c;
        if (b_c == '0) begin
            special = 1'b1;
            spec_q  = '1;
        end else if (!word_i && !uns && a_c == 64'h8000_0000_0000_0000 && b_c == '1) begin
            special = 1'b1;
            spec_q  = a_c;
            spec_r  = '0;
        end else if (!word_i && uns && b_c[63]) begin
            // Divisor >= 2^63: quotient can only be 0 or 1.
            special = 1'b1;
            if (a_c >= b_c) begin
                spec_q = 64'd1;
                spec_r = a_c - b_c;
            end
        end else if (!word_i && uns && a_c[63]) begin
            fix_c = 1'b1;
        end
    end

    assign accept  = valid_i && ready_o && !kill_i;
    // Halved dividend was divided; shift in the dropped LSB and do one restoring step.
    assign r2      = {rem_q[62:0], a0_q};
    assign r2_ge   = (r2 >= op2_q);
    assign sel     = op_q[1] ? rem_q : quo_q;
    assign res_sel = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = !ready_o;
    assign div_vld_o = (state_q == ISSUE) && div_ready_i;
    assign res_vld_o = (state_q == OUT) && !kill_q && !kill_i;
    assign res_o     = res_vld_o ? res_sel : res_q;
    assign div_op1_o = op1_q;
    assign div_op2_o = op2_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        fix_d   = fix_q;
        a0_d    = a0_q;
        kill_d  = kill_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        op1_d   = op1_q;
        op2_d   = op2_q;

        if (state_q != IDLE && kill_i) begin
            kill_d = 1'b1;
        end
        if (res_vld_o) begin
            res_d = res_sel;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op_i;
                    word_d = word_i;
                    fix_d  = fix_c;
                    a0_d   = a_c[0];
                    if (special) begin
                        quo_d   = spec_q;
                        rem_d   = spec_r;
                        state_d = OUT;
                    end else begin
                        op1_d   = fix_c ? (a_c >> 1) : a_c;
                        op2_d   = b_c;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!div_ready_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (div_ready_i) begin
                    quo_d   = div_quo_i;
                    rem_d   = div_rem_i;
                    state_d = fix_q ? FIX : OUT;
                end
            end
            FIX: begin
                quo_d   = {quo_q[62:0], r2_ge};
                rem_d   = r2_ge ? (r2 - op2_q) : r2;
                state_d = OUT;
            end
            OUT: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            fix_q   <= 1'b0;
            a0_q    <= 1'b0;
            kill_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            fix_q   <= fix_d;
            a0_q    <= a0_d;
            kill_q  <= kill_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

endmodule
